// File: rtl/pc_trace_ctrl_pkg.sv
// Shared definitions for the PC trace capture controller: default geometry and FSM state encoding.
package pc_trace_ctrl_pkg;

  localparam int unsigned AW_DEF   = 6;
  localparam int unsigned PC_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } trace_state_e;

endpackage

// File: rtl/pc_trace_ctrl_if.sv
// Trace feed, configuration and pop port of the PC trace controller.
interface pc_trace_ctrl_if import pc_trace_ctrl_pkg::*; #(
  parameter int unsigned AW   = AW_DEF,
  parameter int unsigned PC_W = PC_W_DEF
);
  logic [PC_W-1:0] ie_pc;
  logic            ie_pc_vld;
  logic            cfg_arm;
  logic            cfg_clr;
  logic            cfg_trig_en;
  logic [PC_W-1:0] cfg_trig_pc;
  logic [AW-1:0]   cfg_post_cnt;
  logic            rd_en;
  logic [PC_W-1:0] rd_data;
  logic            rd_vld;
  logic [1:0]      trace_state;
  logic [AW:0]     trace_cnt;
  logic            trig_hit;
  logic            done_irq;

  modport master (
    output ie_pc, ie_pc_vld, cfg_arm, cfg_clr, cfg_trig_en, cfg_trig_pc, cfg_post_cnt, rd_en,
    input  rd_data, rd_vld, trace_state, trace_cnt, trig_hit, done_irq
  );

  modport slave (
    input  ie_pc, ie_pc_vld, cfg_arm, cfg_clr, cfg_trig_en, cfg_trig_pc, cfg_post_cnt, rd_en,
    output rd_data, rd_vld, trace_state, trace_cnt, trig_hit, done_irq
  );

endinterface

// File: rtl/pc_trace_ram.sv
// Trace storage: 2^AW x PC_W, one synchronous write port, one registered read port, no reset.
module pc_trace_ram import pc_trace_ctrl_pkg::*; #(
  parameter int unsigned AW   = AW_DEF,
  parameter int unsigned PC_W = PC_W_DEF
) (
  input  logic            clk,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [PC_W-1:0] wdata_i,
  input  logic            re_i,
  input  logic [AW-1:0]   raddr_i,
  output logic [PC_W-1:0] rdata_o
);

  logic [PC_W-1:0] mem_q [2**AW];
  logic [PC_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pc_trace_ctrl.sv
// PC trace capture controller: arm, trigger on PC match, capture post-trigger entries, drain oldest-first.
module pc_trace_ctrl import pc_trace_ctrl_pkg::*; #(
  parameter int unsigned AW   = AW_DEF,
  parameter int unsigned PC_W = PC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  pc_trace_ctrl_if.slave   bus
);

  localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};

  trace_state_e    state_q;
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   post_rem_q;
  logic [AW:0]     cnt_q;
  logic [PC_W-1:0] last_pc_q;
  logic            last_vld_q;
  logic            trig_hit_q;
  logic            rd_vld_q;
  logic            done_irq_q;
  logic            rd_seen_q;

  logic            capturing;
  logic            sample;
  logic            trig_match;
  logic            wr_en;
  logic            rd_fire;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     cnt_inc;
  logic [PC_W-1:0] ram_rdata;

  always_comb begin
    capturing  = (state_q == ST_ARMED) || (state_q == ST_POST);
    sample     = capturing && bus.ie_pc_vld && (!last_vld_q || (bus.ie_pc != last_pc_q));
    wr_en      = sample && !bus.cfg_clr && !bus.cfg_arm;
    trig_match = bus.cfg_trig_en && (bus.ie_pc == bus.cfg_trig_pc);
    rd_fire    = (state_q == ST_DONE) && bus.rd_en && (cnt_q != '0) && !bus.cfg_clr && !bus.cfg_arm;
    // Oldest entry is wr_ptr - cnt; with wr_ptr frozen in DONE, each pop's decrement
    // of cnt advances this pointer, so no separate read pointer register is kept.
    // A full buffer has zero low bits in cnt, giving rd_ptr = wr_ptr as required.
    rd_ptr     = wr_ptr_q - cnt_q[AW-1:0];
    cnt_inc    = (cnt_q == FULL) ? cnt_q : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      post_rem_q <= '0;
      cnt_q      <= '0;
      last_pc_q  <= '0;
      last_vld_q <= 1'b0;
      trig_hit_q <= 1'b0;
      rd_vld_q   <= 1'b0;
      done_irq_q <= 1'b0;
      rd_seen_q  <= 1'b0;
    end else begin
      rd_vld_q   <= rd_fire;
      done_irq_q <= 1'b0;
      if (rd_fire) rd_seen_q <= 1'b1;

      if (bus.cfg_clr) begin
        state_q    <= ST_IDLE;
        cnt_q      <= '0;
        trig_hit_q <= 1'b0;
        last_vld_q <= 1'b0;
      end else if (bus.cfg_arm) begin
        state_q    <= ST_ARMED;
        wr_ptr_q   <= '0;
        cnt_q      <= '0;
        last_vld_q <= 1'b0;
        trig_hit_q <= 1'b0;
      end else begin
        if (sample) begin
          wr_ptr_q   <= wr_ptr_q + 1'b1;
          cnt_q      <= cnt_inc;
          last_pc_q  <= bus.ie_pc;
          last_vld_q <= 1'b1;
        end
        unique case (state_q)
          ST_ARMED: begin
            if (sample) begin
              if (trig_match) begin
                trig_hit_q <= 1'b1;
                if (bus.cfg_post_cnt == '0) begin
                  state_q    <= ST_DONE;
                  done_irq_q <= 1'b1;
                end else begin
                  state_q    <= ST_POST;
                  post_rem_q <= bus.cfg_post_cnt;
                end
              end else if (!bus.cfg_trig_en && (cnt_inc == FULL)) begin
                state_q    <= ST_DONE;
                done_irq_q <= 1'b1;
              end
            end
          end
          ST_POST: begin
            if (sample) begin
              post_rem_q <= post_rem_q - 1'b1;
              if (post_rem_q == AW'(1)) begin
                state_q    <= ST_DONE;
                done_irq_q <= 1'b1;
              end
            end
          end
          ST_DONE: begin
            if (rd_fire) cnt_q <= cnt_q - 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  pc_trace_ram #(
    .AW   (AW),
    .PC_W (PC_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.ie_pc),
    .re_i    (rd_fire),
    .raddr_i (rd_ptr),
    .rdata_o (ram_rdata)
  );

  // The RAM read register has no reset; mask it until the first pop so rd_data resets to 0.
  assign bus.rd_data     = rd_seen_q ? ram_rdata : '0;
  assign bus.rd_vld      = rd_vld_q;
  assign bus.trace_state = state_q;
  assign bus.trace_cnt   = cnt_q;
  assign bus.trig_hit    = trig_hit_q;
  assign bus.done_irq    = done_irq_q;

endmodule

// File: tb/tb_pc_trace_ctrl.sv
// Directed self-checking bench for pc_trace_ctrl with AW=3 (8-entry buffer).
module tb_pc_trace_ctrl;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  pc_trace_ctrl_if #(.AW(3), .PC_W(32)) bus ();

  pc_trace_ctrl #(.AW(3), .PC_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic arm();
    bus.cfg_arm = 1'b1;
    step();
    bus.cfg_arm = 1'b0;
  endtask

  task automatic feed(input logic [31:0] pc);
    bus.ie_pc     = pc;
    bus.ie_pc_vld = 1'b1;
    step();
    bus.ie_pc_vld = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] exp);
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
    check({tag, "_vld"}, 32'(bus.rd_vld), 32'd1);
    check({tag, "_data"}, bus.rd_data, exp);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, 32'(bus.trace_state), 32'd0);
    check({tag, "_cnt"}, 32'(bus.trace_cnt), 32'd0);
    check({tag, "_trig"}, 32'(bus.trig_hit), 32'd0);
    check({tag, "_rdvld"}, 32'(bus.rd_vld), 32'd0);
    check({tag, "_rddata"}, bus.rd_data, 32'd0);
    check({tag, "_irq"}, 32'(bus.done_irq), 32'd0);
  endtask

  initial begin
    n_checks          = 0;
    n_fail            = 0;
    rst_n             = 1'b0;
    bus.ie_pc         = '0;
    bus.ie_pc_vld     = 1'b0;
    bus.cfg_arm       = 1'b0;
    bus.cfg_clr       = 1'b0;
    bus.cfg_trig_en   = 1'b0;
    bus.cfg_trig_pc   = '0;
    bus.cfg_post_cnt  = '0;
    bus.rd_en         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");
    rst_n = 1'b1;
    step();

    // Full fill without trigger: done after the 8th distinct sample
    arm();
    check("arm_state", 32'(bus.trace_state), 32'd1);
    for (int k = 0; k < 8; k++) begin
      feed(32'h100 + 32'(2 * k));
      if (k == 6) begin
        check("fill7_state", 32'(bus.trace_state), 32'd1);
        check("fill7_cnt", 32'(bus.trace_cnt), 32'd7);
        check("fill7_irq", 32'(bus.done_irq), 32'd0);
      end
    end
    check("fill_state", 32'(bus.trace_state), 32'd3);
    check("fill_irq", 32'(bus.done_irq), 32'd1);
    check("fill_cnt", 32'(bus.trace_cnt), 32'd8);
    step();
    check("fill_irq_once", 32'(bus.done_irq), 32'd0);
    bus.rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("fill_pop_vld", 32'(bus.rd_vld), 32'd1);
      check("fill_pop_data", bus.rd_data, 32'h100 + 32'(2 * i));
    end
    bus.rd_en = 1'b0;
    check("fill_drained_cnt", 32'(bus.trace_cnt), 32'd0);
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
    check("empty_rd_vld", 32'(bus.rd_vld), 32'd0);
    check("empty_rd_cnt", 32'(bus.trace_cnt), 32'd0);
    check("empty_rd_hold", bus.rd_data, 32'h10E);

    // Dedup of repeated PCs, then pops ignored while ARMED
    arm();
    bus.ie_pc     = 32'h200;
    bus.ie_pc_vld = 1'b1;
    repeat (5) step();
    bus.ie_pc = 32'h204;
    step();
    bus.ie_pc_vld = 1'b0;
    check("dedup_cnt", 32'(bus.trace_cnt), 32'd2);
    check("dedup_state", 32'(bus.trace_state), 32'd1);
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
    check("armed_rd_vld", 32'(bus.rd_vld), 32'd0);
    check("armed_rd_cnt", 32'(bus.trace_cnt), 32'd2);

    // Trigger at 0x150 with two post entries after the buffer has wrapped
    bus.cfg_trig_en  = 1'b1;
    bus.cfg_trig_pc  = 32'h150;
    bus.cfg_post_cnt = 3'd2;
    arm();
    for (int k = 0; k <= 60; k++) begin
      feed(32'h100 + 32'(2 * k));
      if (k == 40) begin
        check("trig_state_post", 32'(bus.trace_state), 32'd2);
        check("trig_hit_set", 32'(bus.trig_hit), 32'd1);
      end
      if (k == 42) begin
        check("trig_state_done", 32'(bus.trace_state), 32'd3);
        check("trig_irq", 32'(bus.done_irq), 32'd1);
      end
    end
    check("trig_cnt", 32'(bus.trace_cnt), 32'd8);
    check("trig_hit_sticky", 32'(bus.trig_hit), 32'd1);
    for (int i = 0; i < 8; i++) pop_chk("trig_pop", 32'h146 + 32'(2 * i));

    // Zero post-count: done right after the trigger sample
    bus.cfg_trig_pc  = 32'h300;
    bus.cfg_post_cnt = 3'd0;
    arm();
    feed(32'h2F0);
    feed(32'h2F8);
    check("zp_pre_state", 32'(bus.trace_state), 32'd1);
    feed(32'h300);
    check("zp_state", 32'(bus.trace_state), 32'd3);
    check("zp_irq", 32'(bus.done_irq), 32'd1);
    check("zp_cnt", 32'(bus.trace_cnt), 32'd3);
    pop_chk("zp_pop0", 32'h2F0);
    pop_chk("zp_pop1", 32'h2F8);
    pop_chk("zp_pop2", 32'h300);

    // cfg_clr beats cfg_arm in POST
    bus.cfg_trig_pc  = 32'h400;
    bus.cfg_post_cnt = 3'd3;
    arm();
    feed(32'h3FC);
    feed(32'h400);
    check("prio_in_post", 32'(bus.trace_state), 32'd2);
    bus.cfg_clr = 1'b1;
    bus.cfg_arm = 1'b1;
    step();
    bus.cfg_clr = 1'b0;
    bus.cfg_arm = 1'b0;
    check("clr_state", 32'(bus.trace_state), 32'd0);
    check("clr_cnt", 32'(bus.trace_cnt), 32'd0);
    check("clr_trig", 32'(bus.trig_hit), 32'd0);

    // Re-arm from DONE after a partial drain
    arm();
    feed(32'h400);
    feed(32'h402);
    feed(32'h404);
    check("post_not_done", 32'(bus.trace_state), 32'd2);
    feed(32'h406);
    check("post_done", 32'(bus.trace_state), 32'd3);
    check("post_cnt", 32'(bus.trace_cnt), 32'd4);
    pop_chk("post_pop0", 32'h400);
    arm();
    check("rearm_state", 32'(bus.trace_state), 32'd1);
    check("rearm_cnt", 32'(bus.trace_cnt), 32'd0);
    check("rearm_trig", 32'(bus.trig_hit), 32'd0);

    // Arm coinciding with a sample drops that sample
    bus.ie_pc     = 32'h500;
    bus.ie_pc_vld = 1'b1;
    bus.cfg_arm   = 1'b1;
    step();
    bus.cfg_arm = 1'b0;
    check("arm_drop_cnt", 32'(bus.trace_cnt), 32'd0);
    step();
    bus.ie_pc_vld = 1'b0;
    check("arm_after_cnt", 32'(bus.trace_cnt), 32'd1);

    // Asynchronous reset in the middle of POST
    bus.cfg_trig_pc  = 32'h600;
    bus.cfg_post_cnt = 3'd3;
    arm();
    feed(32'h600);
    check("rst_pre_state", 32'(bus.trace_state), 32'd2);
    rst_n = 1'b0;
    #2;
    check_reset_vals("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    check("post_rst_state", 32'(bus.trace_state), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
